// File: rtl/subtrator_serial_pkg.sv
// subtrator_serial_pkg: shared state encoding for the bit-serial subtractor
package subtrator_serial_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/subtrator_completo.sv
// subtrator_completo: combinational 1-bit full subtractor
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic s,
  output logic bout
);
  assign s    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial unsigned a - b with start/done handshake
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d, bout_q, bout_d;
  logic               s, bout, shift, accept, last;

  subtrator_completo u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (borrow_q),
    .s   (s),
    .bout(bout)
  );

  always_comb begin
    shift    = state_q == ST_SHIFT;
    accept   = start && !shift;
    last     = cnt_q == CNT_W'(WIDTH - 1);
    state_d  = shift ? (last ? ST_DONE : ST_SHIFT) : (start ? ST_SHIFT : ST_IDLE);
    a_d      = accept ? a : (shift ? a_q >> 1 : a_q);
    b_d      = accept ? b : (shift ? b_q >> 1 : b_q);
    r_d      = shift ? {s, r_q[WIDTH-1:1]} : r_q;
    borrow_d = accept ? 1'b0 : (shift ? bout : borrow_q);
    cnt_d    = accept ? '0 : (shift ? cnt_q + 1'b1 : cnt_q);
    diff_d   = shift && last ? {s, r_q[WIDTH-1:1]} : diff_q;
    bout_d   = shift && last ? bout : bout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy       = state_q == ST_SHIFT;
  assign done       = state_q == ST_DONE;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
endmodule

// File: tb/tb_subtrator_serial.sv
// tb_subtrator_serial: directed self-checking bench for subtrator_serial
module tb_subtrator_serial;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start8 = 1'b0, busy8, done8, bo8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       start3 = 1'b0, busy3, done3, bo3;
  logic [2:0] a3 = '0, b3 = '0, diff3;
  int         errs = 0, checks = 0;

  always #5 clk = ~clk;

  subtrator_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  subtrator_serial #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb, input string tag);
    int cyc, busyc;
    start8 = 1'b1; a8 = a; b8 = b;
    step();
    start8 = 1'b0;
    cyc = 0; busyc = 0;
    while (!done8 && cyc < 20) begin
      busyc += int'(busy8);
      step();
      cyc++;
    end
    chk({tag, "_done"}, done8, 1);
    chk({tag, "_busycyc"}, busyc, 8);
    chk({tag, "_diff"}, diff8, ed);
    chk({tag, "_bout"}, bo8, eb);
    step();
    chk({tag, "_pulse"}, done8, 0);
  endtask

  initial begin
    int cyc, donec;
    step();
    step();
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bout", bo8, 0);
    rst = 1'b0;
    step();

    run8(8'd5, 8'd3, 8'h02, 1'b0, "5m3");
    run8(8'd3, 8'd5, 8'hFE, 1'b1, "3m5");
    run8(8'h00, 8'hFF, 8'h01, 1'b1, "0mff");
    run8(8'h80, 8'h80, 8'h00, 1'b0, "80m80");

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        start3 = 1'b1; a3 = 3'(i); b3 = 3'(j);
        step();
        start3 = 1'b0;
        cyc = 0;
        while (!done3 && cyc < 10) begin
          step();
          cyc++;
        end
        chk("w3_done", done3, 1);
        chk("w3_diff", diff3, 32'((i - j) & 7));
        chk("w3_bout", bo3, 32'(i < j));
      end
    step();

    start8 = 1'b1; a8 = 8'd9; b8 = 8'd4;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("b2b_busy1", busy8, 1);
      a8 = 8'(8'hA5 + k * 17); b8 = 8'(8'h3C ^ k);
      step();
    end
    chk("b2b_done1", done8, 1);
    chk("b2b_diff1", diff8, 8'h05);
    chk("b2b_bout1", bo8, 0);
    a8 = 8'd20; b8 = 8'd30;
    step();
    chk("b2b_acc", busy8, 1);
    chk("b2b_nodone", done8, 0);
    for (int k = 0; k < 8; k++) begin
      a8 = 8'(k * 29); b8 = 8'(8'hF0 - k);
      step();
    end
    chk("b2b_done2", done8, 1);
    chk("b2b_diff2", diff8, 8'hF6);
    chk("b2b_bout2", bo8, 1);
    start8 = 1'b0;
    step();
    chk("b2b_idle", busy8 | done8, 0);

    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", busy8, 0);
    chk("mid_done", done8, 0);
    chk("mid_diff", diff8, 0);
    chk("mid_bout", bo8, 0);
    donec = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      donec += int'(done8);
    end
    chk("mid_nodone", donec, 0);
    run8(8'd7, 8'd2, 8'h05, 1'b0, "7m2");

    rst = 1'b1; start8 = 1'b1; a8 = 8'd7; b8 = 8'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rststart_idle", busy8 | done8, 0);
    end
    rst = 1'b0; a8 = 8'd100; b8 = 8'd1;
    step();
    chk("rststart_acc", busy8, 1);
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rststart_done", done8, 1);
    chk("rststart_diff", diff8, 8'd99);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
